// File: rtl/jtoutrun_obj_pkg.sv
`default_nettype none
// ============================================================================
// Module   : jtoutrun_obj_pkg
// Purpose  : Shared types and constants for the OutRun object draw stage:
//            FSM states, line-end pixel code, 1:1 zoom step and the field
//            layout of the line-buffer word.
// Revision : 1.0  initial release
// ============================================================================
package jtoutrun_obj_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAW  = 2'd2
  } obj_state_t;

  localparam logic [3:0] END_CODE_DEF = 4'hF;
  // hzoom has a 9-bit fraction, so one whole source nibble per pixel is 0x200
  localparam logic [9:0] ZOOM_1TO1    = 10'h200;

  // bf_data = {shadow, prio[1:0], pal[6:0], color[3:0]}
  localparam int BF_COL_LSB  = 0;
  localparam int BF_PAL_LSB  = 4;
  localparam int BF_PRIO_LSB = 11;
  localparam int BF_SHD_BIT  = 13;

  function automatic logic [13:0] pack_bf(input logic       shadow,
                                          input logic [1:0] prio,
                                          input logic [6:0] pal,
                                          input logic [3:0] color);
    logic [13:0] v;
    v                     = '0;
    v[BF_COL_LSB  +: 4]   = color;
    v[BF_PAL_LSB  +: 7]   = pal;
    v[BF_PRIO_LSB +: 2]   = prio;
    v[BF_SHD_BIT]         = shadow;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/jtoutrun_obj_zoomstep.sv
`default_nettype none
// ============================================================================
// Module   : jtoutrun_obj_zoomstep
// Purpose  : Horizontal zoom step. Adds hzoom to the 9-bit fractional source
//            position, advances the nibble index by the integer carry (0..2)
//            and flags when the advance runs off the end of the 32-bit word.
// Revision : 1.0  initial release
// ============================================================================
module jtoutrun_obj_zoomstep (
  input  logic [8:0] i_frac,
  input  logic [2:0] i_idx,
  input  logic [9:0] i_hzoom,
  output logic [8:0] o_frac,
  output logic [2:0] o_idx,
  output logic       o_cross
);

  logic [9:0]  w_step;
  logic [10:0] w_sum;
  logic [3:0]  w_idx_sum;

  // zero zoom would hold the source still forever, so it is promoted to the smallest step
  always_comb begin
    w_step    = (i_hzoom == 10'd0) ? 10'd1 : i_hzoom;
    w_sum     = {2'b00, i_frac} + {1'b0, w_step};
    w_idx_sum = {1'b0, i_idx} + {2'b00, w_sum[10:9]};
    o_frac    = w_sum[8:0];
    o_idx     = w_idx_sum[2:0];
    o_cross   = w_idx_sum[3];
  end

endmodule
`default_nettype wire

// File: rtl/jtoutrun_obj_render.sv
`default_nettype none
// ============================================================================
// Module   : jtoutrun_obj_render
// Purpose  : Object draw stage. Takes one draw command per sprite line,
//            fetches 4bpp pixel words from SDRAM, applies horizontal zoom and
//            writes opaque pixels into the object line buffer.
// Config   : JTOUTRUN_OBJ_CLIP_EN - suppress writes outside 0..VIS_W-1 and
//            end the command once the pen leaves the visible window.
// Revision : 1.0  initial release
// ============================================================================
module jtoutrun_obj_render
  import jtoutrun_obj_pkg::*;
#(
  parameter int         VIS_W    = 320,
  parameter logic [3:0] END_CODE = END_CODE_DEF,
  parameter int         MAXPXL   = 511
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hstart,
  input  logic        start,
  output logic        busy,
  input  logic [8:0]  xpos,
  input  logic [15:0] offset,
  input  logic [2:0]  bank,
  input  logic [1:0]  prio,
  input  logic        shadow,
  input  logic [6:0]  pal,
  input  logic        hflip,
  input  logic        backwd,
  input  logic [9:0]  hzoom,
  input  logic        obj_ok,
  output logic        obj_cs,
  output logic [17:0] obj_addr,
  input  logic [31:0] obj_data,
  output logic [8:0]  bf_addr,
  output logic [13:0] bf_data,
  output logic        bf_we
);

`ifdef JTOUTRUN_OBJ_CLIP_EN
  localparam bit C_CLIP = 1'b1;
`else
  localparam bit C_CLIP = 1'b0;
`endif
  localparam logic [9:0] C_VIS_W  = 10'(VIS_W);
  localparam logic [9:0] C_MAXPXL = 10'(MAXPXL);

  obj_state_t  r_st;
  logic [31:0] r_word;
  logic [8:0]  r_x;
  logic [8:0]  r_frac;
  logic [2:0]  r_idx;
  logic [9:0]  r_cnt;
  logic        r_was_in;
  logic [17:0] r_addr_prev;
  logic        r_cs_prev;
  logic        r_shadow;
  logic [1:0]  r_prio;
  logic [6:0]  r_pal;
  logic        r_hflip;
  logic        r_backwd;
  logic [9:0]  r_hzoom;

  logic [31:0] w_shift;
  logic [3:0]  w_color;
  logic [8:0]  w_frac_nxt;
  logic [2:0]  w_idx_nxt;
  logic        w_cross;
  logic        w_accept;
  logic        w_inside;
  logic        w_write_ok;
  logic        w_clip_out;
  logic        w_last;
  logic        w_unused;

  // offset[15] carries hflip on the original board; hflip arrives separately here
  assign w_unused = offset[15];

  jtoutrun_obj_zoomstep u_zoom (
    .i_frac  (r_frac),
    .i_idx   (r_idx),
    .i_hzoom (r_hzoom),
    .o_frac  (w_frac_nxt),
    .o_idx   (w_idx_nxt),
    .o_cross (w_cross)
  );

  // current pixel: forward words start at the top nibble, backward words at the bottom
  always_comb begin
    w_shift    = r_backwd ? (r_word >> {r_idx, 2'b00}) : (r_word << {r_idx, 2'b00});
    w_color    = r_backwd ? w_shift[3:0] : w_shift[31:28];
    // data only counts once the address has been presented for a full cycle
    w_accept   = obj_cs & r_cs_prev & obj_ok & (obj_addr == r_addr_prev);
    w_inside   = {1'b0, r_x} < C_VIS_W;
    w_write_ok = ~C_CLIP | w_inside;
    w_clip_out = C_CLIP & ~w_inside & r_was_in;
    w_last     = (r_cnt + 10'd1) == C_MAXPXL;
  end

  // command FSM with registered SDRAM and line-buffer outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st        <= ST_IDLE;
      busy        <= 1'b0;
      obj_cs      <= 1'b0;
      obj_addr    <= '0;
      bf_we       <= 1'b0;
      bf_addr     <= '0;
      bf_data     <= '0;
      r_word      <= '0;
      r_x         <= '0;
      r_frac      <= '0;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_was_in    <= 1'b0;
      r_addr_prev <= '0;
      r_cs_prev   <= 1'b0;
      r_shadow    <= 1'b0;
      r_prio      <= '0;
      r_pal       <= '0;
      r_hflip     <= 1'b0;
      r_backwd    <= 1'b0;
      r_hzoom     <= ZOOM_1TO1;
    end else begin
      bf_we       <= 1'b0;
      r_addr_prev <= obj_addr;
      r_cs_prev   <= obj_cs;
      if (hstart) begin
        r_st   <= ST_IDLE;
        busy   <= 1'b0;
        obj_cs <= 1'b0;
      end else begin
        case (r_st)
          ST_IDLE: begin
            if (start) begin
              r_shadow <= shadow;
              r_prio   <= prio;
              r_pal    <= pal;
              r_hflip  <= hflip;
              r_backwd <= backwd;
              r_hzoom  <= hzoom;
              obj_addr <= {bank, offset[14:0]};
              r_x      <= xpos;
              r_frac   <= '0;
              r_idx    <= '0;
              r_cnt    <= '0;
              r_was_in <= 1'b0;
              busy     <= 1'b1;
              obj_cs   <= 1'b1;
              r_st     <= ST_FETCH;
            end
          end
          ST_FETCH: begin
            if (w_accept) begin
              r_word   <= obj_data;
              obj_cs   <= 1'b0;
              obj_addr <= r_backwd ? obj_addr - 18'd1 : obj_addr + 18'd1;
              r_st     <= ST_DRAW;
            end
          end
          ST_DRAW: begin
            if (w_color == END_CODE || w_clip_out) begin
              busy <= 1'b0;
              r_st <= ST_IDLE;
            end else begin
              if (w_color != 4'd0 && w_write_ok) begin
                bf_we   <= 1'b1;
                bf_addr <= r_x;
                bf_data <= pack_bf(r_shadow, r_prio, r_pal, w_color);
              end
              if (w_write_ok) r_was_in <= 1'b1;
              r_x    <= r_hflip ? r_x - 9'd1 : r_x + 9'd1;
              r_cnt  <= r_cnt + 10'd1;
              r_frac <= w_frac_nxt;
              r_idx  <= w_idx_nxt;
              if (w_last) begin
                busy <= 1'b0;
                r_st <= ST_IDLE;
              end else if (w_cross) begin
                obj_cs <= 1'b1;
                r_st   <= ST_FETCH;
              end
            end
          end
          default: r_st <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_jtoutrun_obj_render.sv
`default_nettype none
// ============================================================================
// Module   : tb_jtoutrun_obj_render
// Purpose  : Directed self-checking bench for jtoutrun_obj_render with a
//            simple SDRAM responder and a line-buffer write recorder.
// Revision : 1.0  initial release
// ============================================================================
module tb_jtoutrun_obj_render;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hstart = 1'b0;
  logic        start = 1'b0;
  logic        busy;
  logic [8:0]  xpos = '0;
  logic [15:0] offset = '0;
  logic [2:0]  bank = '0;
  logic [1:0]  prio = '0;
  logic        shadow = 1'b0;
  logic [6:0]  pal = '0;
  logic        hflip = 1'b0;
  logic        backwd = 1'b0;
  logic [9:0]  hzoom = 10'h200;
  logic        obj_ok = 1'b0;
  logic        obj_cs;
  logic [17:0] obj_addr;
  logic [31:0] obj_data = '0;
  logic [8:0]  bf_addr;
  logic [13:0] bf_data;
  logic        bf_we;

  jtoutrun_obj_render dut (
    .clk(clk), .rst(rst), .hstart(hstart), .start(start), .busy(busy),
    .xpos(xpos), .offset(offset), .bank(bank), .prio(prio), .shadow(shadow),
    .pal(pal), .hflip(hflip), .backwd(backwd), .hzoom(hzoom),
    .obj_ok(obj_ok), .obj_cs(obj_cs), .obj_addr(obj_addr), .obj_data(obj_data),
    .bf_addr(bf_addr), .bf_data(bf_data), .bf_we(bf_we)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] rom [logic [17:0]];
  logic        hold_ok = 1'b0;
  logic        cs_d = 1'b0;
  logic [31:0] wq[$];
  logic [31:0] eq[$];
  logic [17:0] aq[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] wr(input logic [8:0] x, input logic [3:0] col);
    return {9'd0, x, shadow, prio, pal, col};
  endfunction

  // SDRAM responder and recorders, all on the falling edge
  always @(negedge clk) begin
    obj_ok   = obj_cs && !hold_ok;
    obj_data = rom.exists(obj_addr) ? rom[obj_addr] : 32'hFFFF_FFFF;
    if (bf_we) wq.push_back({9'd0, bf_addr, bf_data});
    if (obj_cs && !cs_d) aq.push_back(obj_addr);
    cs_d = obj_cs;
  end

  task automatic run_cmd(input logic [8:0] x, input logic [15:0] off, input logic [2:0] bk,
                         input logic hf, input logic bw, input logic [9:0] hz, input bit restart);
    int cyc;
    wq.delete();
    aq.delete();
    @(negedge clk);
    xpos = x; offset = off; bank = bk; hflip = hf; backwd = bw; hzoom = hz; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_set", {31'd0, busy}, 32'd1);
    cyc = 0;
    while (busy && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      start = restart && (cyc == 4);
      if (start) xpos = 9'd200;
    end
    start = 1'b0;
    chk("done_in_time", {31'd0, (cyc < 3000)}, 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic cmp_writes;
    chk("wr_cnt", wq.size(), eq.size());
    for (int i = 0; i < eq.size(); i++)
      chk("wr", (i < wq.size()) ? wq[i] : 32'hDEAD_BEEF, eq[i]);
  endtask

  initial begin
    // reset values, checked while reset is held
    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_cs", {31'd0, obj_cs}, 32'd0);
    chk("rst_addr", {14'd0, obj_addr}, 32'd0);
    chk("rst_we", {31'd0, bf_we}, 32'd0);
    chk("rst_bfa", {23'd0, bf_addr}, 32'd0);
    chk("rst_bfd", {18'd0, bf_data}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // 1:1 zoom, forward, one word of colours 1..8 then a terminator
    rom[18'h08100] = 32'h1234_5678;
    rom[18'h08101] = 32'hF000_0000;
    shadow = 1'b1; prio = 2'd2; pal = 7'h55;
    run_cmd(9'd10, 16'h0100, 3'd1, 1'b0, 1'b0, 10'h200, 1'b0);
    eq.delete();
    for (int i = 0; i < 8; i++) eq.push_back(wr(9'(10 + i), 4'(i + 1)));
    cmp_writes();
    chk("t1_busy", {31'd0, busy}, 32'd0);
    chk("t1_nreq", aq.size(), 32'd2);
    chk("t1_a0", {14'd0, aq[0]}, 32'h08100);
    chk("t1_a1", {14'd0, aq[1]}, 32'h08101);

    // 2x stretch; a start pulse mid-command must be ignored
    run_cmd(9'd10, 16'h0100, 3'd1, 1'b0, 1'b0, 10'h100, 1'b1);
    eq.delete();
    for (int i = 0; i < 16; i++) eq.push_back(wr(9'(10 + i), 4'(i / 2 + 1)));
    cmp_writes();

    // backward words, flipped x, near-2x shrink
    rom[18'h10010] = 32'h8765_4321;
    rom[18'h1000F] = 32'h0000_00F0;
    shadow = 1'b0; prio = 2'd1; pal = 7'h12;
    run_cmd(9'd100, 16'h0010, 3'd2, 1'b1, 1'b1, 10'h3FF, 1'b0);
    eq.delete();
    eq.push_back(wr(9'd100, 4'd1));
    eq.push_back(wr(9'd99, 4'd2));
    eq.push_back(wr(9'd98, 4'd4));
    eq.push_back(wr(9'd97, 4'd6));
    eq.push_back(wr(9'd96, 4'd8));
    cmp_writes();
    chk("t3_a0", {14'd0, aq[0]}, 32'h10010);
    chk("t3_a1", {14'd0, aq[1]}, 32'h1000F);

    // transparent gaps; address wraps 0x3FFFF -> 0, offset[15] ignored
    rom[18'h3FFFF] = 32'h1020_3040;
    rom[18'h00000] = 32'hF000_0000;
    shadow = 1'b1; prio = 2'd3; pal = 7'h7F;
    run_cmd(9'd50, 16'hFFFF, 3'd7, 1'b0, 1'b0, 10'h200, 1'b0);
    eq.delete();
    for (int i = 0; i < 4; i++) eq.push_back(wr(9'(50 + 2 * i), 4'(i + 1)));
    cmp_writes();
    chk("t4_a0", {14'd0, aq[0]}, 32'h3FFFF);
    chk("t4_a1", {14'd0, aq[1]}, 32'h00000);

    // hstart aborts a fetch that never gets data
    begin
      int cyc;
      wq.delete();
      hold_ok = 1'b1;
      @(negedge clk);
      xpos = 9'd10; offset = 16'h0100; bank = 3'd1; hzoom = 10'h200; hflip = 1'b0; backwd = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (!obj_cs && cyc < 20) begin @(negedge clk); cyc++; end
      chk("ab_cs_seen", {31'd0, obj_cs}, 32'd1);
      repeat (3) @(negedge clk);
      hstart = 1'b1;
      @(negedge clk);
      hstart = 1'b0;
      chk("ab_cs", {31'd0, obj_cs}, 32'd0);
      chk("ab_busy", {31'd0, busy}, 32'd0);
      hold_ok = 1'b0;
      repeat (10) @(negedge clk);
      chk("ab_nowr", wq.size(), 32'd0);
    end

    // start and hstart together: command dropped
    @(negedge clk);
    start = 1'b1; hstart = 1'b1;
    @(negedge clk);
    start = 1'b0; hstart = 1'b0;
    chk("sh_busy", {31'd0, busy}, 32'd0);
    chk("sh_cs", {31'd0, obj_cs}, 32'd0);

    // right edge of the screen
    rom[18'h0C000] = 32'h1111_1111;
    rom[18'h0C001] = 32'h1111_1111;
    rom[18'h0C002] = 32'hF000_0000;
    shadow = 1'b0; prio = 2'd0; pal = 7'h01;
    run_cmd(9'd316, 16'h4000, 3'd1, 1'b0, 1'b0, 10'h200, 1'b0);
    eq.delete();
`ifdef JTOUTRUN_OBJ_CLIP_EN
    for (int i = 0; i < 4; i++) eq.push_back(wr(9'(316 + i), 4'd1));
`else
    for (int i = 0; i < 16; i++) eq.push_back(wr(9'(316 + i), 4'd1));
`endif
    cmp_writes();

    // long opaque run hits the pixel limit (or the window edge when clipping)
    for (int i = 0; i < 70; i++) rom[18'h20000 + 18'(i)] = 32'h2222_2222;
    run_cmd(9'd0, 16'h0000, 3'd4, 1'b0, 1'b0, 10'h200, 1'b0);
`ifdef JTOUTRUN_OBJ_CLIP_EN
    chk("lim_cnt", wq.size(), 32'd320);
    chk("lim_last", (wq.size() > 0) ? wq[wq.size() - 1] : 32'hDEAD_BEEF, wr(9'd319, 4'd2));
`else
    chk("lim_cnt", wq.size(), 32'd511);
    chk("lim_last", (wq.size() > 0) ? wq[wq.size() - 1] : 32'hDEAD_BEEF, wr(9'd510, 4'd2));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
